// File: rtl/rgb_colour_pkg.sv
// Shared palette definitions for the colour-code <-> RGB converters.
package rgb_colour_pkg;

  localparam int unsigned CHAN_W = 8;
  localparam int unsigned RGB_W  = 24;
  localparam int unsigned CODE_W = 3;

  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [CODE_W-1:0] {
    BLACK   = 3'd0,
    BLUE    = 3'd1,
    GREEN   = 3'd2,
    CYAN    = 3'd3,
    RED     = 3'd4,
    MAGENTA = 3'd5,
    YELLOW  = 3'd6,
    WHITE   = 3'd7
  } colour_e;

  localparam logic [RGB_W-1:0] RGB_BLACK   = 24'h000000;
  localparam logic [RGB_W-1:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] RGB_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] RGB_WHITE   = 24'hFFFFFF;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    colour_e colour;
    logic    exact;
  } class_t;

  // A channel is on the palette rail when fully off or fully on.
  function automatic logic chan_is_rail(input logic [CHAN_W-1:0] c);
    return (c == 8'h00) || (c == 8'hFF);
  endfunction

  // Forward mapping used by the code-to-RGB converter.
  function automatic logic [RGB_W-1:0] palette_rgb(input colour_e code);
    logic [RGB_W-1:0] rgb;
    unique case (code)
      BLACK:   rgb = RGB_BLACK;
      BLUE:    rgb = RGB_BLUE;
      GREEN:   rgb = RGB_GREEN;
      CYAN:    rgb = RGB_CYAN;
      RED:     rgb = RGB_RED;
      MAGENTA: rgb = RGB_MAGENTA;
      YELLOW:  rgb = RGB_YELLOW;
      default: rgb = RGB_WHITE;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/rgb_classify.sv
// Combinational nearest-palette classifier: per-channel threshold plus exact-value flag.
module rgb_classify
  import rgb_colour_pkg::*;
#(
  parameter logic [CHAN_W-1:0] THRESH = 8'h80
) (
  input  logic [RGB_W-1:0] rgb,
  output class_t           cls
);

  rgb_t px;

  always_comb begin
    px.r       = rgb[R_LSB +: CHAN_W];
    px.g       = rgb[G_LSB +: CHAN_W];
    px.b       = rgb[B_LSB +: CHAN_W];
    cls.colour = colour_e'({px.r >= THRESH, px.g >= THRESH, px.b >= THRESH});
    cls.exact  = chan_is_rail(px.r) && chan_is_rail(px.g) && chan_is_rail(px.b);
  end

endmodule

// File: rtl/rgb_to_colour.sv
// Two-stage valid/ready pipeline classifying RGB pixels to 3-bit palette codes,
// with a saturating count of pixels that were not exact palette values.
module rgb_to_colour
  import rgb_colour_pkg::*;
#(
  parameter logic [CHAN_W-1:0] THRESH = 8'h80,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RGB_W-1:0]  rgb_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] colour_out,
  output logic              exact_out,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  nonexact_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  class_t cls_c;
  class_t s1_data;
  class_t s2_data;
  logic   s1_valid;
  logic   s2_valid;
  logic   s2_free;
  logic   s1_adv;
  logic   accept;

  rgb_classify #(.THRESH(THRESH)) u_classify (
    .rgb (rgb_in),
    .cls (cls_c)
  );

  // Handshake: in_ready follows out_ready combinationally through both stages.
  always_comb begin
    s2_free  = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = enable && rst_n && (!s1_valid || s1_adv);
    accept   = in_valid && in_ready;
  end

  // Pipeline registers; enable low freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (enable) begin
      if (s2_free) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
      if (accept) begin
        s1_valid <= 1'b1;
        s1_data  <= cls_c;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Clear is honoured even while disabled and beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonexact_cnt <= '0;
    end else if (clr_cnt) begin
      nonexact_cnt <= '0;
    end else if (accept && !cls_c.exact && (nonexact_cnt != CNT_MAX)) begin
      nonexact_cnt <= nonexact_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = s2_valid;
  assign colour_out = CODE_W'(s2_data.colour);
  assign exact_out  = s2_data.exact;

endmodule

// File: tb/tb_rgb_to_colour.sv
// Self-checking bench for rgb_to_colour against a nearest-palette reference
// model with a transaction queue tracking in-flight pixels.
module tb_rgb_to_colour;

  localparam int unsigned TB_CNT_W = 4;
  localparam int unsigned VW       = 6 + TB_CNT_W;
  localparam logic [TB_CNT_W-1:0] CMAX = '1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic                in_valid;
  logic                in_ready;
  logic [23:0]         rgb_in;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          colour_out;
  logic                exact_out;
  logic                clr_cnt;
  logic [TB_CNT_W-1:0] nonexact_cnt;

  rgb_to_colour #(.THRESH(8'h80), .CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rgb_in       (rgb_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .colour_out   (colour_out),
    .exact_out    (exact_out),
    .clr_cnt      (clr_cnt),
    .nonexact_cnt (nonexact_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] colour;
    logic       exact;
    logic       in_s2;
  } exp_t;

  exp_t                q[$];
  logic [TB_CNT_W-1:0] m_cnt;
  int                  checks;
  int                  errors;

  logic [23:0] pal_px [8];
  logic [23:0] thr_px [4];

  // Nearest palette entry by squared RGB distance; exact when distance is zero.
  function automatic logic [3:0] ref_class(input logic [23:0] px);
    int best_d;
    int best_i;
    int d;
    int pv;
    int lv;
    best_d = 32'h7fffffff;
    best_i = 0;
    for (int i = 0; i < 8; i++) begin
      d = 0;
      for (int c = 0; c < 3; c++) begin
        pv = int'(px[c*8 +: 8]);
        lv = (((i >> c) & 1) != 0) ? 255 : 0;
        d += (pv - lv) * (pv - lv);
      end
      if (d < best_d) begin
        best_d = d;
        best_i = i;
      end
    end
    return {3'(best_i), best_d == 0};
  endfunction

  function automatic logic [23:0] rand_nonexact();
    logic [23:0] p;
    p = 24'($urandom);
    p[23:16] = 8'($urandom_range(1, 254));
    return p;
  endfunction

  // One clock: drive inputs, sample DUT and model expectations, then advance the model.
  task automatic cycle(input logic en, input logic iv, input logic orr, input logic clr,
                       input logic [23:0] px, output logic [VW-1:0] got,
                       output logic [VW-1:0] exp, output logic acc);
    logic       e_ir;
    logic       e_ov;
    logic       xf;
    logic [3:0] rc;
    exp_t       f;
    @(negedge clk);
    enable = en; in_valid = iv; out_ready = orr; clr_cnt = clr; rgb_in = px;
    #1;
    e_ir = en && rst_n && ((q.size() < 2) || orr);
    e_ov = (q.size() > 0) && q[0].in_s2;
    f    = (q.size() > 0) ? q[0] : '0;
    exp  = {e_ir, e_ov, e_ov ? {f.colour, f.exact} : 4'b0, m_cnt};
    got  = {in_ready, out_valid, e_ov ? {colour_out, exact_out} : 4'b0, nonexact_cnt};
    acc  = iv && e_ir;
    xf   = en && e_ov && orr;
    rc   = ref_class(px);
    @(posedge clk);
    if (clr) m_cnt = '0;
    else if (acc && !rc[0] && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
    if (en) begin
      if (xf) void'(q.pop_front());
      if (q.size() > 0) q[0].in_s2 = 1'b1;
      if (acc) q.push_back('{colour: rc[3:1], exact: rc[0], in_s2: 1'b0});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    clr_cnt = 1'b0; rgb_in = 24'hFFFFFF;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, colour_out, exact_out, nonexact_cnt} !== '0) begin
      errors++;
      $display("FAIL reset got ir=%b ov=%b col=%0d ex=%b cnt=%0d exp all zero",
               in_ready, out_valid, colour_out, exact_out, nonexact_cnt);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    q.delete();
    m_cnt = '0;
  endtask

  task automatic test_palette();
    logic [VW-1:0] got, exp;
    logic acc;
    int k = 0;
    for (int i = 0; i < 30 && (k < 8 || q.size() > 0); i++) begin
      cycle(1'b1, k < 8, 1'b1, 1'b0, (k < 8) ? pal_px[k] : 24'h0, got, exp, acc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL palette cyc %0d got %h exp %h", i, got, exp);
      end
      if (acc) k++;
    end
  endtask

  task automatic test_threshold();
    logic [VW-1:0] got, exp;
    logic acc;
    int k = 0;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 24'h0, got, exp, acc);
    for (int i = 0; i < 20 && (k < 4 || q.size() > 0); i++) begin
      cycle(1'b1, k < 4, 1'b1, 1'b0, (k < 4) ? thr_px[k] : 24'h0, got, exp, acc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL threshold cyc %0d got %h exp %h", i, got, exp);
      end
      if (acc) k++;
    end
    #1;
    checks++;
    if (nonexact_cnt !== TB_CNT_W'(4)) begin
      errors++;
      $display("FAIL threshold_cnt got %0d exp 4", nonexact_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] got, exp;
    logic acc;
    logic [23:0] px [6];
    int k = 0;
    for (int j = 0; j < 6; j++) px[j] = pal_px[(j * 3 + 1) % 8] ^ 24'(j);
    for (int i = 0; i < 40 && (k < 6 || q.size() > 0); i++) begin
      cycle(1'b1, k < 6, !(i >= 2 && i < 7), 1'b0, (k < 6) ? px[k] : 24'h0, got, exp, acc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL backpressure cyc %0d got %h exp %h", i, got, exp);
      end
      if (acc) k++;
    end
  endtask

  task automatic test_enable();
    logic [VW-1:0] got, exp;
    logic acc;
    logic [23:0] px;
    int k = 0;
    px = 24'($urandom);
    for (int i = 0; i < 80 && (k < 12 || q.size() > 0); i++) begin
      cycle(((i / 2) % 2) == 0, k < 12, $urandom_range(0, 3) != 0, 1'b0, px, got, exp, acc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL enable cyc %0d got %h exp %h", i, got, exp);
      end
      if (acc) begin
        k++;
        px = 24'($urandom);
      end
    end
  endtask

  task automatic test_saturation();
    logic [VW-1:0] got, exp;
    logic acc;
    int k = 0;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 24'h0, got, exp, acc);
    for (int i = 0; i < 50 && (k < 20 || q.size() > 0); i++) begin
      cycle(1'b1, k < 20, 1'b1, 1'b0, rand_nonexact(), got, exp, acc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL saturation cyc %0d got %h exp %h", i, got, exp);
      end
      if (acc) k++;
    end
    #1;
    checks++;
    if (nonexact_cnt !== CMAX) begin
      errors++;
      $display("FAIL saturation_cnt got %0d exp %0d", nonexact_cnt, CMAX);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1, rand_nonexact(), got, exp, acc);
    #1;
    checks++;
    if (nonexact_cnt !== '0) begin
      errors++;
      $display("FAIL clear_vs_inc got %0d exp 0", nonexact_cnt);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp;
    logic acc;
    for (int i = 0; i < 200; i++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0,
            ($urandom_range(0, 1) != 0) ? pal_px[$urandom_range(0, 7)] : 24'($urandom),
            got, exp, acc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cyc %0d got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] got, exp;
    logic acc;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 24'h123456, got, exp, acc);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 24'h80007F, got, exp, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, nonexact_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset got ov=%b ir=%b cnt=%0d exp 0 0 0",
               out_valid, in_ready, nonexact_cnt);
    end
    q.delete();
    m_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 24'hFF00FF, got, exp, acc);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL post_reset_accept got %h exp %h", got, exp);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, got, exp, acc);
    #1;
    checks++;
    if ({out_valid, colour_out, exact_out} !== {1'b1, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_out got ov=%b col=%0d ex=%b exp 1 5 1",
               out_valid, colour_out, exact_out);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'h0, got, exp, acc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL post_reset_drain cyc %0d got %h exp %h", i, got, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_cnt  = '0;
    pal_px = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
               24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
    thr_px = '{24'h7F7F7F, 24'h808080, 24'h80007F, 24'h12FF80};
    test_reset();
    test_palette();
    test_threshold();
    test_backpressure();
    test_enable();
    test_saturation();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_to_colour.md
Name: rgb_to_colour

Overview:
- Streaming encoder, the inverse of the 3-bit-colour-to-24-bit-RGB converter.
- Takes 24-bit RGB pixels and classifies each to the nearest 3-bit palette code.
- Flags pixels that are not exact palette values and counts them in a saturating counter.
- Sits between a pixel source and colour-code consumers, with valid/ready handshakes on both sides and a global enable.

Parameters:
- THRESH, 8'h80: per-channel threshold; a channel >= THRESH maps to bit 1.
- CNT_W, 16: width of the non-exact pixel counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  high = block runs; low = whole pipeline frozen.
- in_valid  input  1  rgb_in is valid.
- in_ready  output  1  block accepts rgb_in this cycle.
- rgb_in  input  24  pixel, {R[23:16], G[15:8], B[7:0]}.
- out_valid  output  1  colour_out/exact_out are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- colour_out  output  3  palette code, {R_bit, G_bit, B_bit}.
- exact_out  output  1  1 when every channel of the pixel was 8'h00 or 8'hFF.
- clr_cnt  input  1  synchronous clear of nonexact_cnt.
- nonexact_cnt  output  CNT_W  saturating count of accepted non-exact pixels.

Behaviour:
- Palette:
  - 0 black 000000, 1 blue 0000FF, 2 green 00FF00, 3 cyan 00FFFF.
  - 4 red FF0000, 5 magenta FF00FF, 6 yellow FFFF00, 7 white FFFFFF.
  - colour = {R>=THRESH, G>=THRESH, B>=THRESH}; unsigned compares.
- Reset (rst_n low, async): both stage valids = 0, out_valid = 0, colour_out = 0, exact_out = 0, nonexact_cnt = 0. in_ready = 0 while rst_n is low.
- Pipeline: two registered stages.
  - S1 holds the classified code and exact flag.
  - S2 is the output register and drives colour_out/exact_out/out_valid.
- Advance rules, evaluated when enable = 1:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = enable && rst_n && (!s1_valid || s1_adv).
  - in_ready is combinational from out_ready; this path is accepted.
- Accept: in_valid && in_ready at edge N loads S1. The result is in S2 (out_valid = 1) after edge N+1 if s2_free.
  - Latency is 2 edges.
  - Throughput is 1 pixel/cycle with out_ready held high.
- Output hold: while out_valid && !out_ready, colour_out and exact_out stay stable. S1 fills and then in_ready drops; no data is lost or duplicated.
- enable = 0:
  - in_ready = 0.
  - No register changes, including counter increments.
  - out_valid and data are held; a handshake with out_ready is not completed.
  - clr_cnt is still honoured.
- Counter: increments by 1 on each accepted pixel with exact = 0.
  - Saturates at 2^CNT_W-1.
  - clr_cnt sets it to 0 at the next edge; clr_cnt wins over a simultaneous increment.
- Order: outputs appear in exactly input order.
- Reset mid-stream: all in-flight pixels are discarded and the counter is cleared. After release, the first output is the first pixel accepted after release.

Decomposition:
- Shared package rgb_colour_pkg holds:
  - palette code constants (BLACK..WHITE = 3'd0..3'd7);
  - the 24-bit palette RGB constants;
  - the channel field offsets.
- The converter and this block both use the package.
- One natural sub-module: rgb_classify, purely combinational. It maps rgb_in to {colour, exact} using THRESH and is instantiated once before S1.

Test Plan:
- Palette sweep: out_ready = 1, enable = 1; feed 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF back-to-back.
  - colour_out = 0..7 in order, exact_out = 1 each.
  - First out_valid 2 edges after the first accept; nonexact_cnt = 0.
- Threshold boundary: feed 7F7F7F, 808080, 80007F, 12FF80.
  - colour_out = 0, 7, 4, 3; exact_out = 0 for all; nonexact_cnt = 4.
- Backpressure: stream 6 distinct pixels, out_ready = 0 for 5 cycles mid-stream.
  - in_ready falls after both stages fill; colour_out is stable while stalled.
  - All 6 codes are delivered once each, in order.
- Enable gating: toggle enable every 2 cycles during a stream (matches the converter bench enable pattern).
  - No accepts or output transfers while enable = 0; sequence intact; counter only advances when enable = 1.
- Counter saturation/clear: CNT_W = 4; feed 20 non-exact pixels.
  - nonexact_cnt = 15 and holds.
  - Assert clr_cnt in the same cycle as another non-exact accept → 0 next edge.
- Async reset mid-stream: drop rst_n with both stages full.
  - out_valid = 0 and nonexact_cnt = 0 immediately, without waiting for clk.
  - After release, the next accepted pixel FF00FF → colour_out = 5.
